// File: rtl/calc_display_driver.sv
// rtl/calc_display_driver.sv - eight-digit seven-segment driver with hex / double-dabble decimal readout
module calc_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dato,
    input  logic        mode,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] val_q;
    logic        mode_q;
    logic [15:0] src;
    logic [19:0] bcd, bcd_adj;
    logic [3:0]  cnt;
    logic [19:0] disp, commit_val;
    logic [2:0]  ndig, commit_nd;
    logic [RW-1:0] rc;
    logic [2:0]  idx;
    logic        capture;
    logic        lit;
    logic [31:0] disp_ext;
    logic [3:0]  digit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Leading-zero blanking: position of the top nonzero digit plus one, never below 1.
    function automatic logic [2:0] digits_used(input logic [19:0] d);
        digits_used = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (d[i*4 +: 4] != 4'h0) digits_used = 3'(i + 1);
        end
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign commit_val = mode_q ? bcd : {4'h0, val_q};
    assign commit_nd  = digits_used(commit_val);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if ((dato != val_q) || (mode != mode_q)) begin
                    capture   = 1'b1;
                    state_nxt = mode ? SHIFT : COMMIT;
                end
            end
            SHIFT:   if (cnt == 4'd15) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            val_q  <= 16'h0;
            mode_q <= 1'b0;
            src    <= 16'h0;
            bcd    <= 20'h0;
            cnt    <= 4'h0;
            disp   <= 20'h0;
            ndig   <= 3'd1;
        end else begin
            state <= state_nxt;
            if (capture) begin
                val_q  <= dato;
                mode_q <= mode;
                src    <= dato;
                bcd    <= 20'h0;
                cnt    <= 4'h0;
            end
            if (state == SHIFT) begin
                bcd <= {bcd_adj[18:0], src[15]};
                src <= {src[14:0], 1'b0};
                cnt <= cnt + 4'd1;
            end
            // disp only changes here, so the visible digits never show a half-built value.
            if (state == COMMIT) begin
                disp <= commit_val;
                ndig <= commit_nd;
            end
        end
    end

    assign disp_ext = {12'h0, disp};
    assign digit    = disp_ext[{idx, 2'b00} +: 4];
    assign lit      = (idx < ndig);

    always_ff @(posedge clk) begin
        if (rst) begin
            rc  <= '0;
            idx <= 3'd0;
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            if (rc == RC_LAST) begin
                rc  <= '0;
                idx <= idx + 3'd1;
            end else begin
                rc <= rc + 1'b1;
            end
            an  <= lit ? ~(8'd1 << idx) : 8'hFF;
            seg <= lit ? glyph(digit) : 7'h7F;
        end
    end

    assign dp_n = 1'b1;
    assign busy = (state != IDLE);

endmodule
